// File: rtl/phase_lock_pkg.sv
// Shared definitions for the phase-lock sequencer: state encoding and
// default parameter values.
package phase_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } pl_state_e;

  localparam int DEF_CNT_W    = 3;
  localparam int DEF_LOCK_LEN = 5;
  localparam int DEF_MISS_MAX = 2;

endpackage

// File: rtl/streak_counter.sv
// Saturating up-counter used to hold the consecutive-match streak.
// clr wins over inc; the count sticks at all-ones instead of wrapping.
module streak_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  // Counter register: clear, or increment until saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/phase_lock_ctrl.sv
// Phase-lock sequencer: toggles a phase bit while active, tracks how many
// consecutive cycles the input matches it, declares lock after LOCK_LEN
// matches and drops lock after MISS_MAX consecutive misses while locked.
module phase_lock_ctrl
  import phase_lock_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_LEN = DEF_LOCK_LEN,
  parameter int MISS_MAX = DEF_MISS_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             i,
  output logic             phase,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] streak,
  output logic             locked,
  output logic             lock_pulse,
  output logic             lost_pulse
);

  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

  // Reject parameter sets the lock/miss compares cannot represent.
  generate
    if ((LOCK_LEN < 1) || (LOCK_LEN > (2**CNT_W) - 1)) begin : g_bad_lock_len
      $error("phase_lock_ctrl: LOCK_LEN must be in 1..2**CNT_W-1");
    end
    if (MISS_MAX < 1) begin : g_bad_miss_max
      $error("phase_lock_ctrl: MISS_MAX must be >= 1");
    end
  endgenerate

  pl_state_e         state_reg, state_next;
  logic              phase_reg, phase_next;
  logic [MISS_W-1:0] miss_cnt_reg, miss_cnt_next;
  logic              locked_reg, locked_next;
  logic              lock_pulse_reg, lock_pulse_next;
  logic              lost_pulse_reg, lost_pulse_next;
  logic              streak_clr, streak_inc;
  logic [CNT_W-1:0]  streak_cnt;
  logic              match;

  // The comparison always uses the phase value held before the edge.
  assign match = (i == phase_reg);

  streak_counter #(
    .CNT_W(CNT_W)
  ) u_streak (
    .clk (clk),
    .rst (rst),
    .clr (streak_clr),
    .inc (streak_inc),
    .cnt (streak_cnt)
  );

  // State, phase, miss counter and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= 1'b0;
      miss_cnt_reg   <= '0;
      locked_reg     <= 1'b0;
      lock_pulse_reg <= 1'b0;
      lost_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      miss_cnt_reg   <= miss_cnt_next;
      locked_reg     <= locked_next;
      lock_pulse_reg <= lock_pulse_next;
      lost_pulse_reg <= lost_pulse_next;
    end
  end

  // Next-state logic; abort overrides any lock or loss decided this cycle.
  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    miss_cnt_next   = miss_cnt_reg;
    streak_clr      = 1'b0;
    streak_inc      = 1'b0;
    lock_pulse_next = 1'b0;
    lost_pulse_next = 1'b0;

    if (abort) begin
      state_next    = ST_IDLE;
      phase_next    = 1'b0;
      miss_cnt_next = '0;
      streak_clr    = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          phase_next    = 1'b0;
          miss_cnt_next = '0;
          streak_clr    = 1'b1;
          if (start) begin
            state_next = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          phase_next = ~phase_reg;
          if (match) begin
            streak_inc = 1'b1;
            if (streak_cnt == LOCK_LAST) begin
              state_next      = ST_LOCKED;
              miss_cnt_next   = '0;
              lock_pulse_next = 1'b1;
            end
          end else begin
            streak_clr = 1'b1;
          end
        end
        ST_LOCKED: begin
          phase_next = ~phase_reg;
          if (match) begin
            streak_inc    = 1'b1;
            miss_cnt_next = '0;
          end else begin
            streak_clr    = 1'b1;
            miss_cnt_next = miss_cnt_reg + 1'b1;
            if (miss_cnt_reg == MISS_LAST) begin
              state_next      = ST_LOST;
              lost_pulse_next = 1'b1;
            end
          end
        end
        default: begin
          // ST_LOST: a single cleanup cycle before searching again.
          phase_next    = ~phase_reg;
          miss_cnt_next = '0;
          streak_clr    = 1'b1;
          state_next    = ST_SEARCH;
        end
      endcase
    end

    locked_next = (state_next == ST_LOCKED);
  end

  assign phase      = phase_reg;
  assign state      = state_reg;
  assign streak     = streak_cnt;
  assign locked     = locked_reg;
  assign lock_pulse = lock_pulse_reg;
  assign lost_pulse = lost_pulse_reg;

endmodule

// File: tb/tb_phase_lock_ctrl.sv
// Directed plus randomized bench for phase_lock_ctrl with a behavioural
// reference model of the lock/miss rules.
module tb_phase_lock_ctrl;

  localparam int CNT_W    = 3;
  localparam int LOCK_LEN = 5;
  localparam int MISS_MAX = 2;
  localparam int SAT      = (2**CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             i = 1'b0;
  logic             phase;
  logic [1:0]       state;
  logic [CNT_W-1:0] streak;
  logic             locked;
  logic             lock_pulse;
  logic             lost_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: mode 0 idle, 1 searching, 2 locked, 3 lost.
  int m_mode   = 0;
  bit m_phase  = 1'b0;
  int m_streak = 0;
  int m_miss   = 0;
  bit m_lp     = 1'b0;
  bit m_lo     = 1'b0;

  phase_lock_ctrl #(
    .CNT_W(CNT_W), .LOCK_LEN(LOCK_LEN), .MISS_MAX(MISS_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .i(i),
    .phase(phase), .state(state), .streak(streak), .locked(locked),
    .lock_pulse(lock_pulse), .lost_pulse(lost_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 1'b0; m_streak = 0; m_miss = 0; m_lp = 1'b0; m_lo = 1'b0;
  endtask

  // Apply one clock's worth of rules to the model.
  task automatic model_step(input bit s, input bit a, input bit iv);
    bit hit;
    hit  = (iv == m_phase);
    m_lp = 1'b0;
    m_lo = 1'b0;
    if (a) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_phase = 1'b0; m_streak = 0; m_miss = 0;
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      m_phase = !m_phase;
      if (hit) begin
        m_streak = (m_streak + 1 > SAT) ? SAT : m_streak + 1;
        if (m_streak == LOCK_LEN) begin
          m_mode = 2; m_miss = 0; m_lp = 1'b1;
        end
      end else begin
        m_streak = 0;
      end
    end else if (m_mode == 2) begin
      m_phase = !m_phase;
      if (hit) begin
        m_streak = (m_streak + 1 > SAT) ? SAT : m_streak + 1;
        m_miss = 0;
      end else begin
        m_streak = 0;
        m_miss++;
        if (m_miss == MISS_MAX) begin
          m_mode = 3; m_lo = 1'b1;
        end
      end
    end else begin
      m_phase = !m_phase; m_streak = 0; m_miss = 0; m_mode = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  8'(state),      8'(m_mode));
    chk({tag, ".phase"},  8'(phase),      8'(m_phase));
    chk({tag, ".streak"}, 8'(streak),     8'(m_streak));
    chk({tag, ".locked"}, 8'(locked),     8'(m_mode == 2));
    chk({tag, ".lockp"},  8'(lock_pulse), 8'(m_lp));
    chk({tag, ".lostp"},  8'(lost_pulse), 8'(m_lo));
    chk({tag, ".excl"},   8'(lock_pulse & lost_pulse), 8'd0);
    if (locked === 1'b1)
      chk({tag, ".inv_lock"}, 8'((streak != 0) || (m_miss != 0)), 8'd1);
  endtask

  // One clock: drive inputs, advance model, check after the edge.
  task automatic cycle(input string tag, input bit s, input bit a, input bit iv);
    start = s; abort = a; i = iv;
    model_step(s, a, iv);
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d %s start=%0b abort=%0b i=%0b -> st=%0d ph=%0b streak=%0d lk=%0b lp=%0b lo=%0b",
             cyc, tag, s, a, iv, state, phase, streak, locked, lock_pulse, lost_pulse);
    check_all(tag);
  endtask

  // Same as cycle, choosing i to match or miss the expected phase.
  task automatic mcycle(input string tag, input bit s, input bit a, input bit want_match);
    cycle(tag, s, a, want_match ? m_phase : !m_phase);
  endtask

  initial begin
    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;

    // 1: asynchronous reset mid-SEARCH with streak 3.
    mcycle("t1_start", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) mcycle("t1_match", 1'b0, 1'b0, 1'b1);
    chk("t1_streak3", 8'(streak), 8'd3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t1_async_rst");
    #2 rst = 1'b0;

    // 2: start then five matches lock; pulse lasts one cycle.
    mcycle("t2_start", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) mcycle("t2_match", 1'b0, 1'b0, 1'b1);
    chk("t2_lock_pulse", 8'(lock_pulse), 8'd1);
    chk("t2_locked", 8'(locked), 8'd1);
    chk("t2_streak5", 8'(streak), 8'd5);
    mcycle("t2_hold", 1'b0, 1'b0, 1'b1);
    chk("t2_pulse_gone", 8'(lock_pulse), 8'd0);

    // 3: isolated misses keep lock; two consecutive misses lose it.
    mcycle("t3_miss", 1'b0, 1'b0, 1'b0);
    mcycle("t3_hit",  1'b0, 1'b0, 1'b1);
    mcycle("t3_miss", 1'b0, 1'b0, 1'b0);
    chk("t3_still_locked", 8'(locked), 8'd1);
    mcycle("t3_hit",  1'b0, 1'b0, 1'b1);
    mcycle("t3_miss", 1'b0, 1'b0, 1'b0);
    mcycle("t3_miss", 1'b0, 1'b0, 1'b0);
    chk("t3_lost_pulse", 8'(lost_pulse), 8'd1);
    chk("t3_lost_state", 8'(state), 8'd3);
    mcycle("t3_after", 1'b0, 1'b0, 1'b1);
    chk("t3_search", 8'(state), 8'd1);
    chk("t3_streak0", 8'(streak), 8'd0);

    // 4: a miss at streak 4 restarts the count.
    for (int k = 0; k < 4; k++) mcycle("t4_match", 1'b0, 1'b0, 1'b1);
    mcycle("t4_miss", 1'b0, 1'b0, 1'b0);
    chk("t4_streak0", 8'(streak), 8'd0);
    chk("t4_nolock", 8'(locked), 8'd0);
    for (int k = 0; k < 4; k++) mcycle("t4_match", 1'b0, 1'b0, 1'b1);
    chk("t4_not_yet", 8'(locked), 8'd0);
    mcycle("t4_match5", 1'b0, 1'b0, 1'b1);
    chk("t4_locked", 8'(locked), 8'd1);

    // 5: long lock saturates the streak.
    for (int k = 0; k < 12; k++) mcycle("t5_match", 1'b0, 1'b0, 1'b1);
    chk("t5_sat", 8'(streak), 8'd7);

    // 6: abort wins over a same-cycle lock; start while locked is ignored.
    mcycle("t6_abort", 1'b0, 1'b1, 1'b1);
    mcycle("t6_start", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) mcycle("t6_match", 1'b0, 1'b0, 1'b1);
    mcycle("t6_abort5", 1'b0, 1'b1, 1'b1);
    chk("t6_idle", 8'(state), 8'd0);
    chk("t6_no_pulse", 8'(lock_pulse), 8'd0);
    mcycle("t6_both", 1'b1, 1'b1, 1'b0);
    chk("t6_both_idle", 8'(state), 8'd0);
    mcycle("t6_start", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) mcycle("t6_match", 1'b0, 1'b0, 1'b1);
    mcycle("t6_start_lk", 1'b1, 1'b0, 1'b1);
    chk("t6_stay_locked", 8'(state), 8'd2);

    // Randomized traffic, biased toward matches so locks occur.
    for (int k = 0; k < 400; k++) begin
      mcycle("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 4) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
